dump_arbiter: RTL and testbench
===============================

# dump_arbiter

Round-robin scheduler that shares one real-value dump sink among N fixed-point producers. It accepts samples from each requester over a valid/ready handshake and applies per-channel decimation. Forwarded records are tagged with their channel index and presented on a single registered output that feeds the file-dump stage. It also enforces a global record budget, after which it drains and flags completion.

## Interface
- N, 4, number of requester channels (≥2)
- WIDTH, 16, fixed-point real width per channel
- EXPONENT, -8, fixed-point exponent shared by all channels, passed through unchanged
- DECIM, 1, forward every DECIM-th accepted sample per channel (≥1)
- MAX_RECORDS, 0, forwarded-record budget; 0 = unlimited

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- enable  input  1  run request; low parks the arbiter
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH], signed
- in_valid  input  N  per-channel sample valid
- in_ready  output  N  per-channel accept, combinational
- out_data  output  WIDTH  registered forwarded sample
- out_chan  output  $clog2(N)  channel index of out_data
- out_valid  output  1  record present
- out_ready  input  1  sink accepts record
- done  output  1  budget exhausted
- rec_count  output  32  records forwarded since reset

## Operation
- States: IDLE, RUN, DONE.
  - Reset enters IDLE.
  - IDLE→RUN when enable=1.
  - RUN→IDLE when enable=0. The pending output record still completes its handshake.
  - RUN→DONE on the edge that loads record number MAX_RECORDS, when MAX_RECORDS≠0.
  - DONE is left only by reset.
- Slot free = !out_valid || out_ready.
- Grant in RUN when the slot is free. Grant goes to the first channel with in_valid=1, searching from ptr upward and wrapping at N-1→0. in_ready is one-hot on the granted channel, otherwise all zero.
- On a handshake with channel g:
  - ptr ← (g+1) mod N.
  - dcnt[g] ← (dcnt[g]==DECIM-1) ? 0 : dcnt[g]+1.
  - If the old dcnt[g]==0, the sample is forwarded: out_data←in_data[g], out_chan←g, out_valid←1, rec_count+1.
  - Otherwise the sample is discarded and the output register is untouched.
- Output register: out_valid clears on out_valid&&out_ready with no new load. A load and a drain in the same cycle replace the record, so out_valid stays 1.
- IDLE: in_ready=0; ptr and dcnt hold.
- DONE:
  - in_ready = all ones, so producers never stall; samples are discarded.
  - No further loads; rec_count frozen; done=1.
  - The last record still drains via out_ready.
- rec_count saturates at 2^32-1.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, done=0, rec_count=0, in_ready=0. ptr=0, all dcnt=0, state=IDLE.
- Reset mid-record drops the pending record with no handshake.
- Latency: a handshake at edge k gives out_valid=1 after edge k.
- Throughput is one accept per cycle while out_ready=1.
- in_ready depends combinationally on in_valid, out_valid, out_ready and state. It has no dependence on in_data.
- enable sampled low at edge k: in_ready=0 from cycle k+1. A grant in cycle k still completes.
- If the budget is reached and enable falls at the same edge, DONE takes priority.
- A sustained out_ready=0 holds out_data/out_chan stable and in_ready=0 in RUN.
- DECIM=1: every accepted sample is forwarded.

## Test plan
- N=4, all valid continuously, out_ready=1, enable=1 → out_chan sequence 0,1,2,3,0,… one record per cycle; first out_valid one cycle after the first grant.
- Only channels 1 and 3 valid; out_ready toggles 1,0,1,0 → out_chan alternates 1,3; out_data is stable while out_ready=0; no samples lost or duplicated.
- DECIM=3, channel 2 alone sends 7 samples, values 10..16 → forwarded 10, 13, 16; rec_count=3; in_ready was high for all 7.
- MAX_RECORDS=5 with all channels streaming → done=1 after the 5th load; rec_count=5; in_ready=4'b1111 thereafter; the 5th record drains when out_ready=1.
- enable dropped mid-stream with out_ready=0 → in_ready=0 next cycle; the held record drains when out_ready rises; on re-enable, arbitration resumes from the saved ptr.
- rst=0 asserted while out_valid=1 → next cycle all outputs are at reset values; after release with enable=1, the first grant goes to channel 0.

Source files
------------

// File: rtl/dump_arbiter.sv
// dump_arbiter: round-robin sharing of one registered dump sink among N producers,
// with per-channel decimation and an optional global forwarded-record budget.
module dump_arbiter #(
    parameter int          N           = 4,
    parameter int          WIDTH       = 16,
    parameter int          EXPONENT    = -8,
    parameter int          DECIM       = 1,
    parameter int unsigned MAX_RECORDS = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_chan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done,
    output logic [31:0]            rec_count
);

    localparam int CW = $clog2(N);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The exponent only describes the fixed-point format downstream; data passes unchanged.
    logic unused_exponent;
    assign unused_exponent = (EXPONENT != 0);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [DW-1:0]    dcnt_q [N];
    logic [DW-1:0]    dcnt_d [N];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_chan_q, out_chan_d;
    logic [31:0]      rec_count_q, rec_count_d;

    logic [WIDTH-1:0] chan_data [N];
    logic             gnt_found;
    logic [CW-1:0]    gnt_idx;
    logic [CW-1:0]    scan_idx;
    logic             slot_free;
    logic             grant;
    logic             fwd;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            chan_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // First requester at or after ptr, wrapping past N-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = CW'((32'(ptr_q) + k) % N);
            if (!gnt_found && in_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign grant     = (state_q == S_RUN) && slot_free && gnt_found;
    assign fwd       = grant && (dcnt_q[gnt_idx] == '0);

    always_comb begin
        in_ready = '0;
        if (state_q == S_DONE) begin
            in_ready = '1;
        end else if (grant) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        dcnt_d      = dcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rec_count_d = rec_count_q;

        if (grant) begin
            ptr_d = (gnt_idx == CW'(N-1)) ? '0 : gnt_idx + 1'b1;
            dcnt_d[gnt_idx] = (dcnt_q[gnt_idx] == DW'(DECIM-1)) ? '0 : dcnt_q[gnt_idx] + 1'b1;
        end

        // A load during a drain replaces the record, so valid stays high.
        if (fwd) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[gnt_idx];
            out_chan_d  = gnt_idx;
            if (rec_count_q != '1) begin
                rec_count_d = rec_count_q + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                if (fwd && (MAX_RECORDS != 0) && (rec_count_d == MAX_RECORDS)) begin
                    state_d = S_DONE;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                dcnt_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            dcnt_q      <= dcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rec_count_q <= rec_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign rec_count = rec_count_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_dump_arbiter.sv
// Randomised bench for dump_arbiter: a transaction-level model predicts grants, decimation
// and the record budget; forwarded records are queued and matched when the sink accepts them.
module tb_dump_arbiter;

    localparam int          NCH  = 4;
    localparam int          W    = 16;
    localparam int          DEC  = 3;
    localparam int unsigned MAXR = 30;
    localparam int          NPH  = 5;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic [NCH*W-1:0] in_data = '0;
    logic [NCH-1:0]   in_valid = '0;
    logic [NCH-1:0]   in_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       out_chan;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             done;
    logic [31:0]      rec_count;

    always #5 clk = ~clk;

    dump_arbiter #(
        .N(NCH),
        .WIDTH(W),
        .EXPONENT(-8),
        .DECIM(DEC),
        .MAX_RECORDS(MAXR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_chan(out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done(done),
        .rec_count(rec_count)
    );

    int checks = 0;
    int failures = 0;
    logic [17:0] sbq[$];

    int          m_st;
    int          m_ptr;
    int unsigned m_acc [NCH];
    bit          m_ov;
    logic [W-1:0] m_od;
    int          m_oc;
    longint      m_rec;

    // Phase table: cycles, channel mask, valid %, ready mode (0 random, 1 always, 2 toggle), enable-drop %.
    int         ph_cyc  [NPH] = '{110, 120, 150, 150, 200};
    logic [3:0] ph_mask [NPH] = '{4'hF, 4'hA, 4'hF, 4'h4, 4'hF};
    int         ph_vp   [NPH] = '{100, 100, 60, 70, 50};
    int         ph_rm   [NPH] = '{1, 2, 0, 0, 0};
    int         ph_ed   [NPH] = '{0, 5, 10, 5, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = ST_IDLE;
        m_ptr = 0;
        for (int i = 0; i < NCH; i++) m_acc[i] = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_oc  = 0;
        m_rec = 0;
        sbq.delete();
    endtask

    function automatic logic [NCH-1:0] exp_ready();
        logic [NCH-1:0] r;
        r = '0;
        if (m_st == ST_DONE) return '1;
        if (m_st == ST_RUN && (!m_ov || out_ready)) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (in_valid[c]) begin
                    r[c] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_step();
        logic [NCH-1:0] r;
        int g;
        bit load;
        if (!rst) begin
            model_reset();
            return;
        end
        r = exp_ready();
        g = -1;
        load = 1'b0;
        if (m_st == ST_RUN) begin
            for (int i = 0; i < NCH; i++) if (r[i]) g = i;
        end
        if (g >= 0) begin
            load = (m_acc[g] % DEC) == 0;
            m_acc[g]++;
            m_ptr = (g + 1) % NCH;
        end
        if (load) begin
            m_ov = 1'b1;
            m_od = in_data[g*W +: W];
            m_oc = g;
            m_rec++;
            sbq.push_back({2'(g), m_od});
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if (m_st == ST_IDLE) begin
            if (enable) m_st = ST_RUN;
        end else if (m_st == ST_RUN) begin
            if (load && MAXR != 0 && m_rec == longint'(MAXR)) m_st = ST_DONE;
            else if (!enable) m_st = ST_IDLE;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_od));
        chk("out_chan", 64'(out_chan), 64'(m_oc));
        chk("done", 64'(done), 64'(m_st == ST_DONE));
        chk("rec_count", 64'(rec_count), 64'(m_rec));
    endtask

    task automatic drive(input int p, input int c);
        rst    = (c >= 2);
        enable = ($urandom_range(0, 99) >= ph_ed[p]);
        for (int i = 0; i < NCH; i++) begin
            in_valid[i] = ph_mask[p][i] && ($urandom_range(0, 99) < ph_vp[p]);
        end
        in_data = {$urandom, $urandom};
        case (ph_rm[p])
            1:       out_ready = 1'b1;
            2:       out_ready = c[0];
            default: out_ready = ($urandom_range(0, 99) < 70);
        endcase
    endtask

    // Sink-side monitor: every accepted record must match the oldest predicted one.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got chan %0d data 0x%0h expected no record at %0t",
                             out_chan, out_data, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_chan", 64'(out_chan), 64'(e[17:16]));
                    chk("sb_data", 64'(out_data), 64'(e[15:0]));
                end
            end
        end
    end

    initial begin
        int total;
        total = 0;
        model_reset();
        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < ph_cyc[p]; c++) begin
                @(posedge clk);
                #1;
                if (total > 0) check_outputs();
                drive(p, c);
                #1;
                if (total > 0) chk("in_ready", 64'(in_ready), 64'(exp_ready()));
                model_step();
                total++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
